// File: rtl/ysyx_22040759_mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, FSM encodings,
// load/store func3 encodings and the byte-mask helper.
package ysyx_22040759_mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 173;
  localparam int MS_TO_WS_BUS_WD = 166;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } ms_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte-enable pattern for an aligned access of 2**size bytes at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ysyx_22040759_lsu_align.sv
// Combinational lane steering: store strobe/data generation and
// load extraction with sign/zero extension.
module ysyx_22040759_lsu_align
  import ysyx_22040759_mem_stage_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [2:0]  offset,
  input  logic [63:0] store_data,
  input  logic [63:0] load_word,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata,
  output logic [63:0] load_data
);

  logic [5:0]  shamt_s;
  logic [63:0] shifted_s;

  assign shamt_s   = {offset, 3'b000};
  assign wstrb     = size_mask(func3[1:0]) << offset;
  assign wdata     = store_data << shamt_s;
  assign shifted_s = load_word >> shamt_s;

  // Pick the loaded bytes out of lane 0 and extend them to 64 bits.
  always_comb begin
    load_data = 64'd0;
    case (func3)
      F3_B:    load_data = {{56{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    load_data = {{48{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    load_data = {{32{shifted_s[31]}}, shifted_s[31:0]};
      F3_D:    load_data = shifted_s;
      F3_BU:   load_data = {56'd0, shifted_s[7:0]};
      F3_HU:   load_data = {48'd0, shifted_s[15:0]};
      F3_WU:   load_data = {32'd0, shifted_s[31:0]};
      default: load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/ysyx_22040759_mem_stage.sv
// MEM pipeline stage: holds one instruction from EXE, runs its load/store
// through the req/addr_ok/data_ok bridge protocol and forwards to WB.
module ysyx_22040759_mem_stage
  import ysyx_22040759_mem_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         es_to_ms_valid,
  input  logic [172:0] es_to_ms_bus,
  input  logic [63:0]  alu_result,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [165:0] ms_to_ws_bus,
  output logic [63:0]  ms_alu_result,
  output logic [4:0]   ms_rd,
  output logic         ms_reg_wen,
  output logic         ms_load_pending,
  output logic         data_req,
  output logic         data_wr,
  output logic [1:0]   data_size,
  output logic [63:0]  data_addr,
  output logic [7:0]   data_wstrb,
  output logic [63:0]  data_wdata,
  input  logic         data_addr_ok,
  input  logic [63:0]  data_rdata,
  input  logic         data_data_ok
);

  ms_state_e     state_r;
  ms_state_e     state_nxt_s;
  logic          ms_valid_r;
  logic [172:0]  bus_r;
  logic [63:0]   alu_r;
  logic [63:0]   load_buf_r;

  logic          data_req_s;
  logic          done_s;
  logic          capture_s;
  logic          ready_go_s;
  logic          accept_s;
  logic          es_mem_s;
  logic          mem_op_s;
  logic [7:0]    wstrb_s;
  logic [63:0]   wdata_s;
  logic [63:0]   load_data_s;
  logic [63:0]   final_s;
  logic          unused_wreg_sel_s;

  logic [31:0]   inst_s;
  logic [63:0]   src2_s;
  logic          mem_wen_s;
  logic          mem_ren_s;
  logic [2:0]    func3_s;
  logic          reg_wen_s;
  logic [4:0]    rd_s;
  logic [63:0]   pc_s;

  assign inst_s    = bus_r[172:141];
  assign src2_s    = bus_r[140:77];
  assign mem_wen_s = bus_r[76];
  assign mem_ren_s = bus_r[75];
  assign func3_s   = bus_r[74:72];
  assign reg_wen_s = bus_r[69];
  assign rd_s      = bus_r[68:64];
  assign pc_s      = bus_r[63:0];
  assign unused_wreg_sel_s = ^bus_r[71:70];

  assign es_mem_s   = es_to_ms_bus[76] | es_to_ms_bus[75];
  assign mem_op_s   = mem_wen_s | mem_ren_s;
  assign ready_go_s = ~mem_op_s | done_s;
  assign ms_allowin = ~ms_valid_r | (ready_go_s & ws_allowin);
  assign accept_s   = es_to_ms_valid & ms_allowin;
  assign ms_to_ws_valid = ms_valid_r & ready_go_s;

  // Advance the bus-transaction FSM; reset abandons any open transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a newly latched memory instruction always restarts at REQ.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s & es_mem_s) state_nxt_s = ST_REQ;
        else                     state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (data_addr_ok & data_data_ok) state_nxt_s = ST_DONE;
        else if (data_addr_ok)           state_nxt_s = ST_WAIT;
        else                             state_nxt_s = ST_REQ;
      end
      ST_WAIT: begin
        if (data_data_ok) state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_WAIT;
      end
      ST_DONE: begin
        if (accept_s & es_mem_s) state_nxt_s = ST_REQ;
        else if (ws_allowin)     state_nxt_s = ST_IDLE;
        else                     state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: request strobe, completion flag and data_ok acceptance window.
  always_comb begin
    data_req_s = 1'b0;
    done_s     = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_REQ: begin
        data_req_s = 1'b1;
        capture_s  = data_addr_ok & data_data_ok;
      end
      ST_WAIT: capture_s = data_data_ok;
      ST_DONE: done_s = 1'b1;
      default: data_req_s = 1'b0;
    endcase
  end

  // Stage valid bit follows EXE whenever the stage can take a new entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ms_valid_r <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_r <= es_to_ms_valid;
    end else begin
      ms_valid_r <= ms_valid_r;
    end
  end

  // Payload registers; held stable while a transaction is outstanding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_r <= 173'd0;
      alu_r <= 64'd0;
    end else if (accept_s) begin
      bus_r <= es_to_ms_bus;
      alu_r <= alu_result;
    end else begin
      bus_r <= bus_r;
      alu_r <= alu_r;
    end
  end

  // Load buffer captures read data only on an accepted data_ok.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_buf_r <= 64'd0;
    end else if (capture_s) begin
      load_buf_r <= data_rdata;
    end else begin
      load_buf_r <= load_buf_r;
    end
  end

  ysyx_22040759_lsu_align u_align (
    .func3      (func3_s),
    .offset     (alu_r[2:0]),
    .store_data (src2_s),
    .load_word  (load_buf_r),
    .wstrb      (wstrb_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s)
  );

  assign final_s      = mem_ren_s ? load_data_s : alu_r;
  assign ms_to_ws_bus = {inst_s, reg_wen_s, rd_s, final_s, pc_s};

  assign ms_alu_result   = alu_r;
  assign ms_rd           = ms_valid_r ? rd_s : 5'd0;
  assign ms_reg_wen      = reg_wen_s & ms_valid_r;
  assign ms_load_pending = ms_valid_r & mem_ren_s & ~done_s;

  assign data_req   = data_req_s;
  assign data_wr    = mem_wen_s;
  assign data_size  = func3_s[1:0];
  assign data_addr  = alu_r;
  assign data_wstrb = mem_wen_s ? wstrb_s : 8'h00;
  assign data_wdata = mem_wen_s ? wdata_s : 64'd0;

endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Directed self-checking bench for the MEM stage.
module tb_ysyx_22040759_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         es_to_ms_valid;
  logic [172:0] es_to_ms_bus;
  logic [63:0]  alu_result;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [165:0] ms_to_ws_bus;
  logic [63:0]  ms_alu_result;
  logic [4:0]   ms_rd;
  logic         ms_reg_wen;
  logic         ms_load_pending;
  logic         data_req;
  logic         data_wr;
  logic [1:0]   data_size;
  logic [63:0]  data_addr;
  logic [7:0]   data_wstrb;
  logic [63:0]  data_wdata;
  logic         data_addr_ok;
  logic [63:0]  data_rdata;
  logic         data_data_ok;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ysyx_22040759_mem_stage dut (
    .clk(clk), .rst(rst), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .alu_result(alu_result), .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ms_alu_result(ms_alu_result),
    .ms_rd(ms_rd), .ms_reg_wen(ms_reg_wen), .ms_load_pending(ms_load_pending),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok)
  );

  function automatic logic [172:0] mk_bus(input logic [31:0] inst, input logic [63:0] src2,
                                          input logic wen, input logic ren, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [63:0] pc);
    return {inst, src2, wen, ren, f3, 2'b01, 1'b1, rd, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = 173'd0; alu_result = 64'd0;
    ws_allowin = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 64'd0;
    tick(); tick();
    rst = 1'b1; #1;
    total_cnt++; if (ms_to_ws_valid !== 1'b0) $display("FAIL reset_valid got %h exp 0", ms_to_ws_valid); else pass_cnt++;
    total_cnt++; if (data_req !== 1'b0) $display("FAIL reset_req got %h exp 0", data_req); else pass_cnt++;
    total_cnt++; if (ms_allowin !== 1'b1) $display("FAIL reset_allowin got %h exp 1", ms_allowin); else pass_cnt++;
    total_cnt++; if (ms_to_ws_bus !== 166'd0) $display("FAIL reset_bus got %h exp 0", ms_to_ws_bus); else pass_cnt++;
    total_cnt++; if (ms_load_pending !== 1'b0) $display("FAIL reset_pending got %h exp 0", ms_load_pending); else pass_cnt++;
    total_cnt++; if (ms_rd !== 5'd0) $display("FAIL reset_rd got %h exp 0", ms_rd); else pass_cnt++;
  endtask

  task automatic test_alu();
    es_to_ms_valid = 1'b1; alu_result = 64'h1234;
    es_to_ms_bus = mk_bus(32'h0000_0013, 64'd0, 1'b0, 1'b0, 3'b000, 5'd5, 64'h8000_0000);
    #1;
    total_cnt++; if (ms_allowin !== 1'b1) $display("FAIL alu_allowin got %h exp 1", ms_allowin); else pass_cnt++;
    tick();
    es_to_ms_valid = 1'b0; #1;
    total_cnt++; if (ms_to_ws_valid !== 1'b1) $display("FAIL alu_valid got %h exp 1", ms_to_ws_valid); else pass_cnt++;
    total_cnt++; if (ms_to_ws_bus[127:64] !== 64'h1234) $display("FAIL alu_result got %h exp 1234", ms_to_ws_bus[127:64]); else pass_cnt++;
    total_cnt++; if (data_req !== 1'b0) $display("FAIL alu_noreq got %h exp 0", data_req); else pass_cnt++;
    total_cnt++; if (ms_rd !== 5'd5 || ms_reg_wen !== 1'b1) $display("FAIL alu_hazard got rd=%h wen=%h exp rd=05 wen=1", ms_rd, ms_reg_wen); else pass_cnt++;
    total_cnt++; if (ms_alu_result !== 64'h1234) $display("FAIL alu_fwd got %h exp 1234", ms_alu_result); else pass_cnt++;
    tick();
    total_cnt++; if (ms_to_ws_valid !== 1'b0) $display("FAIL alu_drain got %h exp 0", ms_to_ws_valid); else pass_cnt++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t  [7] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110, 3'b011, 3'b101};
    logic [63:0] adr_t [7] = '{64'h8003, 64'h8003, 64'h8002, 64'h8004, 64'h8004, 64'h8000, 64'h8006};
    logic [63:0] rd_t  [7] = '{64'h0000_0000_80FF_0000, 64'h0000_0000_80FF_0000, 64'h0000_0000_80FF_0000,
                               64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000, 64'h1122_3344_5566_7788,
                               64'hF00D_0000_0000_0000};
    logic [63:0] exp_t [7] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_80FF,
                               64'hFFFF_FFFF_8765_4321, 64'h0000_0000_8765_4321, 64'h1122_3344_5566_7788,
                               64'h0000_0000_0000_F00D};
    for (int i = 0; i < 7; i++) begin
      es_to_ms_valid = 1'b1; alu_result = adr_t[i];
      es_to_ms_bus = mk_bus(32'h0000_0003, 64'd0, 1'b0, 1'b1, f3_t[i], 5'd10, 64'h8000_0100);
      tick();
      es_to_ms_valid = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rd_t[i]; #1;
      total_cnt++; if (data_req !== 1'b1 || data_wr !== 1'b0) $display("FAIL load%0d_req got req=%h wr=%h exp req=1 wr=0", i, data_req, data_wr); else pass_cnt++;
      total_cnt++; if (data_addr !== adr_t[i]) $display("FAIL load%0d_addr got %h exp %h", i, data_addr, adr_t[i]); else pass_cnt++;
      total_cnt++; if (ms_load_pending !== 1'b1) $display("FAIL load%0d_pending got %h exp 1", i, ms_load_pending); else pass_cnt++;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 64'hDEAD_BEEF_DEAD_BEEF; #1;
      total_cnt++; if (ms_to_ws_valid !== 1'b1) $display("FAIL load%0d_valid got %h exp 1", i, ms_to_ws_valid); else pass_cnt++;
      total_cnt++; if (ms_to_ws_bus[127:64] !== exp_t[i]) $display("FAIL load%0d_data got %h exp %h", i, ms_to_ws_bus[127:64], exp_t[i]); else pass_cnt++;
      total_cnt++; if (ms_load_pending !== 1'b0) $display("FAIL load%0d_done got %h exp 0", i, ms_load_pending); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3_t  [4] = '{3'b001, 3'b010, 3'b000, 3'b011};
    logic [63:0] adr_t [4] = '{64'h0006, 64'h0004, 64'h0005, 64'h0000};
    logic [63:0] src_t [4] = '{64'hABCD, 64'h1234_5678, 64'h77, 64'h0102_0304_0506_0708};
    logic [7:0]  stb_t [4] = '{8'hC0, 8'hF0, 8'h20, 8'hFF};
    logic [63:0] wd_t  [4] = '{64'hABCD_0000_0000_0000, 64'h1234_5678_0000_0000,
                               64'h0000_7700_0000_0000, 64'h0102_0304_0506_0708};
    for (int i = 0; i < 4; i++) begin
      es_to_ms_valid = 1'b1; alu_result = adr_t[i];
      es_to_ms_bus = mk_bus(32'h0000_0023, src_t[i], 1'b1, 1'b0, f3_t[i], 5'd0, 64'h8000_0200);
      tick();
      es_to_ms_valid = 1'b0; data_addr_ok = 1'b1; #1;
      total_cnt++; if (data_wstrb !== stb_t[i]) $display("FAIL store%0d_wstrb got %h exp %h", i, data_wstrb, stb_t[i]); else pass_cnt++;
      total_cnt++; if (data_wdata !== wd_t[i]) $display("FAIL store%0d_wdata got %h exp %h", i, data_wdata, wd_t[i]); else pass_cnt++;
      total_cnt++; if (data_wr !== 1'b1 || data_req !== 1'b1 || data_size !== f3_t[i][1:0]) $display("FAIL store%0d_ctl got wr=%h req=%h size=%h exp 1 1 %h", i, data_wr, data_req, data_size, f3_t[i][1:0]); else pass_cnt++;
      tick();
      data_addr_ok = 1'b0; #1;
      total_cnt++; if (data_req !== 1'b0 || ms_to_ws_valid !== 1'b0) $display("FAIL store%0d_wait got req=%h valid=%h exp 0 0", i, data_req, ms_to_ws_valid); else pass_cnt++;
      data_data_ok = 1'b1;
      tick();
      data_data_ok = 1'b0; #1;
      total_cnt++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[127:64] !== adr_t[i]) $display("FAIL store%0d_retire got valid=%h res=%h exp 1 %h", i, ms_to_ws_valid, ms_to_ws_bus[127:64], adr_t[i]); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_delay();
    int ret = 0;
    es_to_ms_valid = 1'b1; alu_result = 64'h10;
    es_to_ms_bus = mk_bus(32'h0000_3003, 64'd0, 1'b0, 1'b1, 3'b011, 5'd12, 64'h8000_0300);
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (data_req !== 1'b1 || data_addr !== 64'h10) $display("FAIL delay_req%0d got req=%h addr=%h exp 1 10", i, data_req, data_addr); else pass_cnt++;
      total_cnt++; if (ms_allowin !== 1'b0 || ms_load_pending !== 1'b1) $display("FAIL delay_stall%0d got allowin=%h pend=%h exp 0 1", i, ms_allowin, ms_load_pending); else pass_cnt++;
      tick();
    end
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++; if (data_req !== 1'b0 || ms_load_pending !== 1'b1 || ms_to_ws_valid !== 1'b0) $display("FAIL delay_wait%0d got req=%h pend=%h valid=%h exp 0 1 0", i, data_req, ms_load_pending, ms_to_ws_valid); else pass_cnt++;
      tick();
    end
    data_data_ok = 1'b1; data_rdata = 64'hCAFE_F00D_1234_5678;
    tick();
    data_data_ok = 1'b0; #1;
    total_cnt++; if (ms_to_ws_bus[127:64] !== 64'hCAFE_F00D_1234_5678) $display("FAIL delay_data got %h exp cafef00d12345678", ms_to_ws_bus[127:64]); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (ms_to_ws_valid && ws_allowin) ret++;
      tick();
    end
    total_cnt++; if (ret !== 1) $display("FAIL delay_retires got %0d exp 1", ret); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [165:0] exp_bus;
    exp_bus = {32'h0000_A003, 1'b1, 5'd7, 64'h1111_2222_3333_4444, 64'h100};
    es_to_ms_valid = 1'b1; alu_result = 64'h20;
    es_to_ms_bus = mk_bus(32'h0000_A003, 64'd0, 1'b0, 1'b1, 3'b011, 5'd7, 64'h100);
    tick();
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 64'h1111_2222_3333_4444;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    es_to_ms_valid = 1'b1; alu_result = 64'h28;
    es_to_ms_bus = mk_bus(32'h0000_B003, 64'd0, 1'b0, 1'b1, 3'b011, 5'd9, 64'h104);
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_bus) $display("FAIL b2b_hold%0d got valid=%h bus=%h exp 1 %h", i, ms_to_ws_valid, ms_to_ws_bus, exp_bus); else pass_cnt++;
      total_cnt++; if (ms_allowin !== 1'b0 || data_req !== 1'b0) $display("FAIL b2b_block%0d got allowin=%h req=%h exp 0 0", i, ms_allowin, data_req); else pass_cnt++;
      tick();
    end
    ws_allowin = 1'b1; #1;
    total_cnt++; if (ms_allowin !== 1'b1) $display("FAIL b2b_allowin got %h exp 1", ms_allowin); else pass_cnt++;
    tick();
    es_to_ms_valid = 1'b0; #1;
    total_cnt++; if (data_req !== 1'b1 || data_addr !== 64'h28) $display("FAIL b2b_next_req got req=%h addr=%h exp 1 28", data_req, data_addr); else pass_cnt++;
    total_cnt++; if (ms_to_ws_valid !== 1'b0 || ms_rd !== 5'd9) $display("FAIL b2b_next_state got valid=%h rd=%h exp 0 09", ms_to_ws_valid, ms_rd); else pass_cnt++;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 64'h5555_6666_7777_8888;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
    total_cnt++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[127:64] !== 64'h5555_6666_7777_8888) $display("FAIL b2b_next_data got valid=%h res=%h exp 1 5555666677778888", ms_to_ws_valid, ms_to_ws_bus[127:64]); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_in_wait();
    es_to_ms_valid = 1'b1; alu_result = 64'h30;
    es_to_ms_bus = mk_bus(32'h0000_C003, 64'd0, 1'b0, 1'b1, 3'b011, 5'd3, 64'h200);
    tick();
    es_to_ms_valid = 1'b0; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; #1;
    total_cnt++; if (data_req !== 1'b0 || ms_load_pending !== 1'b1) $display("FAIL rstw_inwait got req=%h pend=%h exp 0 1", data_req, ms_load_pending); else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1; #1;
    total_cnt++; if (ms_to_ws_valid !== 1'b0 || ms_load_pending !== 1'b0 || ms_rd !== 5'd0) $display("FAIL rstw_cleared got valid=%h pend=%h rd=%h exp 0 0 00", ms_to_ws_valid, ms_load_pending, ms_rd); else pass_cnt++;
    total_cnt++; if (ms_allowin !== 1'b1 || data_req !== 1'b0) $display("FAIL rstw_idle got allowin=%h req=%h exp 1 0", ms_allowin, data_req); else pass_cnt++;
    data_data_ok = 1'b1; data_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    data_data_ok = 1'b0; #1;
    total_cnt++; if (ms_to_ws_valid !== 1'b0 || data_req !== 1'b0 || ms_load_pending !== 1'b0) $display("FAIL rstw_stray got valid=%h req=%h pend=%h exp 0 0 0", ms_to_ws_valid, data_req, ms_load_pending); else pass_cnt++;
    es_to_ms_valid = 1'b1; alu_result = 64'h38;
    es_to_ms_bus = mk_bus(32'h0000_D003, 64'd0, 1'b0, 1'b1, 3'b011, 5'd4, 64'h204);
    tick();
    es_to_ms_valid = 1'b0; #1;
    total_cnt++; if (data_req !== 1'b1 || data_addr !== 64'h38) $display("FAIL rstw_reissue got req=%h addr=%h exp 1 38", data_req, data_addr); else pass_cnt++;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 64'h0BAD_F00D_0000_0001;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
    total_cnt++; if (ms_to_ws_bus[127:64] !== 64'h0BAD_F00D_0000_0001) $display("FAIL rstw_data got %h exp 0badf00d00000001", ms_to_ws_bus[127:64]); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_stores();
    test_delay();
    test_back_to_back();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish before 100000");
    $fatal(1);
  end

endmodule
